// File: rtl/score_event_sequencer.sv
// ----------------------------------------------------------------------------
// score_event_sequencer
//
// Sits between the game logic and a 4-digit packed-BCD score counter. Food and
// bonus events become credits. Each credit is issued to the counter as one
// single-cycle increment pulse, and at least GAP_CYCLES low cycles follow
// every pulse. The block also sequences a new game (clears the counter) and
// game over (drains the remaining credits, lets the counter settle, updates
// the high score, then freezes).
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   food_eaten   1-cycle pulse, +1 credit
//   bonus_eaten  1-cycle pulse, +BONUS_PTS credits
//   game_over    1-cycle pulse, drain then freeze
//   new_game     1-cycle pulse, abort and clear (high score kept)
//   score_in     packed BCD score read back from the counter {d3,d2,d1,d0}
//   inc_pulse    counter increment, one cycle wide
//   score_rst    counter clear
//   high_score   packed BCD best score, cleared only by rst
//   pending      credits not yet issued
//   busy         high unless the FSM is in IDLE or FROZEN
//   dropped      1-cycle flag: a credit was lost to saturation
//   state_dbg    current FSM state encoding (debug visibility)
//
// Handshake: there is no back-pressure. Every input is a one-cycle pulse that
// is sampled on the rising edge of clk. inc_pulse and score_rst are one-cycle
// strobes to the counter, and the counter must accept them unconditionally.
// ----------------------------------------------------------------------------
module score_event_sequencer #(
    parameter int BONUS_PTS  = 5,
    parameter int PEND_W     = 6,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              food_eaten,
    input  logic              bonus_eaten,
    input  logic              game_over,
    input  logic              new_game,
    input  logic [15:0]       score_in,
    output logic              inc_pulse,
    output logic              score_rst,
    output logic [15:0]       high_score,
    output logic [PEND_W-1:0] pending,
    output logic              busy,
    output logic              dropped,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_IDLE   = 3'd1,
        S_ISSUE  = 3'd2,
        S_GAP    = 3'd3,
        S_SETTLE = 3'd4,
        S_FROZEN = 3'd5
    } state_t;

    // Two spare bits let pending + add overflow past the maximum count so
    // that saturation can be detected.
    localparam int                SUM_W    = PEND_W + 2;
    localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [SUM_W-1:0]  PEND_MAX = {2'b00, {PEND_W{1'b1}}};
    localparam logic [SUM_W-1:0]  BONUS_V  = SUM_W'(BONUS_PTS);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t             state, next_state;
    logic               go_seen;
    logic [GAP_W-1:0]   gap_cnt;
    logic               settle_cnt;

    logic               accept;
    logic               go_now;
    logic               take;
    logic               clip;
    logic               capture;
    logic [SUM_W-1:0]   add;
    logic [SUM_W-1:0]   avail;
    logic [SUM_W-1:0]   diff;
    logic [PEND_W-1:0]  pend_next;

    assign state_dbg = state;

    always_comb begin
        accept     = 1'b0;
        add        = '0;
        avail      = '0;
        go_now     = 1'b0;
        next_state = state;
        take       = 1'b0;
        diff       = '0;
        clip       = 1'b0;
        pend_next  = pending;
        capture    = 1'b0;

        // Credits and game_over count only while a game is live. new_game
        // outranks everything, so it also masks events in the same cycle.
        accept = (state != S_CLEAR) && (state != S_FROZEN) && !new_game;
        if (accept) begin
            add = {{(SUM_W-1){1'b0}}, food_eaten} + (bonus_eaten ? BONUS_V : '0);
        end
        avail  = {2'b00, pending} + add;
        go_now = go_seen | (game_over & accept);

        if (new_game) begin
            next_state = S_CLEAR;
        end else begin
            case (state)
                S_CLEAR:  next_state = S_IDLE;
                S_IDLE: begin
                    if (avail != '0)  next_state = S_ISSUE;
                    else if (go_now)  next_state = S_SETTLE;
                end
                S_ISSUE:  next_state = S_GAP;
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (avail != '0)  next_state = S_ISSUE;
                        else if (go_now)  next_state = S_SETTLE;
                        else              next_state = S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt) next_state = S_FROZEN;
                end
                S_FROZEN: next_state = S_FROZEN;
                default:  next_state = S_CLEAR;
            endcase
        end

        // Each entry into ISSUE consumes one credit.
        take = (next_state == S_ISSUE);
        diff = avail - {{(SUM_W-1){1'b0}}, take};
        if ((next_state == S_CLEAR) || (state == S_CLEAR)) begin
            pend_next = '0;
        end else if (diff > PEND_MAX) begin
            clip      = 1'b1;
            pend_next = PEND_MAX[PEND_W-1:0];
        end else begin
            pend_next = diff[PEND_W-1:0];
        end

        // Last SETTLE cycle. By now the counter has absorbed the final pulse.
        capture = (state == S_SETTLE) && settle_cnt && !new_game;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            pending    <= '0;
            go_seen    <= 1'b0;
            gap_cnt    <= '0;
            settle_cnt <= 1'b0;
            inc_pulse  <= 1'b0;
            score_rst  <= 1'b1;
            busy       <= 1'b1;
            dropped    <= 1'b0;
            high_score <= '0;
        end else begin
            state      <= next_state;
            pending    <= pend_next;
            go_seen    <= (next_state == S_CLEAR) ? 1'b0 : go_now;
            gap_cnt    <= ((next_state == S_GAP) && (state == S_GAP)) ? gap_cnt + 1'b1 : '0;
            settle_cnt <= (state == S_SETTLE) && (next_state == S_SETTLE);
            inc_pulse  <= (next_state == S_ISSUE);
            score_rst  <= (next_state == S_CLEAR);
            busy       <= !((next_state == S_IDLE) || (next_state == S_FROZEN));
            dropped    <= clip;
            // Packed BCD orders the same way as binary, so a plain compare works.
            if (capture && (score_in > high_score)) begin
                high_score <= score_in;
            end
        end
    end

endmodule

// File: tb/tb_score_event_sequencer.sv
module tb_score_event_sequencer;

  localparam int BONUS = 5;
  localparam int PW    = 6;
  localparam int GAP   = 1;
  localparam int PMAX  = (1 << PW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          food_eaten = 1'b0;
  logic          bonus_eaten = 1'b0;
  logic          game_over = 1'b0;
  logic          new_game = 1'b0;
  logic [15:0]   score_in = 16'h0000;
  logic          inc_pulse;
  logic          score_rst;
  logic [15:0]   high_score;
  logic [PW-1:0] pending;
  logic          busy;
  logic          dropped;
  logic [2:0]    state_dbg;

  score_event_sequencer #(
    .BONUS_PTS (BONUS),
    .PEND_W    (PW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .food_eaten (food_eaten),
    .bonus_eaten(bonus_eaten),
    .game_over  (game_over),
    .new_game   (new_game),
    .score_in   (score_in),
    .inc_pulse  (inc_pulse),
    .score_rst  (score_rst),
    .high_score (high_score),
    .pending    (pending),
    .busy       (busy),
    .dropped    (dropped),
    .state_dbg  (state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- attached 4-digit BCD counter ----------------
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v == 16'h9999) return v;
    for (int d = 0; d < 4; d++) begin
      if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
      else begin
        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
        break;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (score_rst === 1'b1) score_in <= 16'h0000;
    else if (inc_pulse === 1'b1) score_in <= bcd_inc(score_in);
  end

  function automatic logic [15:0] to_bcd(input int n);
    int m;
    m = (n > 9999) ? 9999 : n;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [PW-1:0] pend;
    logic          drop;
    logic          srst;
  } cyc_exp_t;

  logic [31:0] exp_q[$];     // cycles in which inc_pulse must be high
  cyc_exp_t    cyc_q[$];     // per-cycle expected pending / dropped / score_rst

  // Reference model. A credit earned in cycle c can be paid out no earlier
  // than c+1, and consecutive pulses lie at least GAP+1 cycles apart.
  // Credits are ignored in the clear cycle and while the game is frozen.
  int owed = 0;
  int next_ok = 0;
  int game_pts = 0;
  int high_exp = 0;
  bit m_clear = 1'b0;
  bit m_frozen = 1'b0;

  task automatic step(input bit f, input bit b, input bit go, input bit ng, input bit r);
    int a;
    int s;
    cyc_exp_t e;
    @(posedge clk);
    #1;
    food_eaten = f; bonus_eaten = b; game_over = go; new_game = ng; rst = r;
    e.cyc = cyc + 1; e.drop = 1'b0; e.srst = 1'b0;
    if (r || ng) begin
      owed = 0; game_pts = 0; m_frozen = 1'b0; m_clear = 1'b1; e.srst = 1'b1;
      if (r) high_exp = 0;
    end else if (m_clear || m_frozen) begin
      m_clear = 1'b0;
    end else begin
      a = int'(f) + (b ? BONUS : 0);
      s = owed + a;
      if (s > 0 && cyc + 1 >= next_ok) begin
        exp_q.push_back(32'(cyc + 1));
        next_ok = cyc + 2 + GAP;
        game_pts++;
        s--;
      end
      e.drop = (s > PMAX);
      owed = (s > PMAX) ? PMAX : s;
    end
    e.pend = PW'(owed);
    cyc_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Wait until the drain plus settle must have ended, then check the frozen result.
  task automatic finish_game(input string tag);
    idle(2 * owed + 8);
    if (game_pts > high_exp) high_exp = game_pts;
    @(negedge clk);
    chk({tag, "_high_score"}, 32'(high_score), 32'(to_bcd(high_exp)));
    chk({tag, "_state_frozen"}, 32'(state_dbg), 32'd5);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    m_frozen = 1'b1;
    step(1, 0, 0, 0, 0);     // ignored while frozen
    idle(3);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc_exp_t e;
    if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
      e = cyc_q.pop_front();
      chk("pending", 32'(pending), 32'(e.pend));
      chk("dropped", 32'(dropped), 32'(e.drop));
      chk("score_rst", 32'(score_rst), 32'(e.srst));
    end
    if (inc_pulse === 1'b1) begin
      if (exp_q.size() == 0) chk("pulse_extra", 32'(cyc), 32'hffffffff);
      else chk("pulse_cycle", 32'(cyc), exp_q.pop_front());
    end else if (exp_q.size() > 0 && exp_q[0] <= 32'(cyc)) begin
      chk("pulse_missing", 32'(cyc), exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("rst_high_score", 32'(high_score), 32'h0);
    chk("rst_inc_pulse", 32'(inc_pulse), 32'h0);
    chk("rst_state_clear", 32'(state_dbg), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    step(0, 0, 0, 0, 0);     // CLEAR
    idle(2);

    // Single food from IDLE: one pulse at t+1, busy through t+2
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk); chk("food_busy_t1", 32'(busy), 32'h1);
    step(0, 0, 0, 0, 0);
    @(negedge clk); chk("food_busy_t2", 32'(busy), 32'h1);
    step(0, 0, 0, 0, 0);
    @(negedge clk); chk("food_busy_t3", 32'(busy), 32'h0);
    idle(2);

    // Bonus: five pulses every other cycle
    step(0, 1, 0, 0, 0);
    idle(12);

    // Food and bonus together, plus one food during the drain
    step(1, 1, 0, 0, 0);
    idle(4);
    step(1, 0, 0, 0, 0);
    idle(16);

    // Saturation of the pending counter
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    finish_game("sat");

    // Game over with pending=3 in GAP
    step(0, 0, 0, 1, 0);
    idle(3);
    step(0, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 0, 0);
    finish_game("go");

    // new_game while issuing: abort, high score kept
    step(0, 0, 0, 1, 0);
    idle(3);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(6);
    @(negedge clk);
    chk("abort_high_kept", 32'(high_score), 32'(to_bcd(high_exp)));

    // Random games
    for (int g = 0; g < 8; g++) begin
      int n;
      n = $urandom_range(20, 60);
      step(0, 0, 0, 1, 0);
      idle(2);
      for (int i = 0; i < n; i++)
        step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, 0, 0, 0);
      if ($urandom_range(0, 3) == 0) begin
        step($urandom_range(0, 1) == 1, 0, 0, 1, 0);
        idle(4);
      end else begin
        step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 1, 0, 0);
        finish_game("rand");
      end
    end

    // rst in the middle of a drain
    step(0, 0, 0, 1, 0);
    idle(2);
    step(0, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_mid_high_zero", 32'(high_score), 32'h0);
    idle(10);

    @(negedge clk);
    chk("pulses_left", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
